instr_fetch: RTL and testbench

Instruction fetch unit for the SAP/MARIE datapath. It initiates reads on the synchronous program ROM port, assembling one- and two-word instructions (opcode word plus optional operand word), and presents them to the decoder over a valid/ready handshake. It owns the program counter and accepts jump redirects from the control unit.

---
 rtl/instr_fetch_if.sv | 43 ++++
 rtl/instr_fetch.sv | 176 +++++++++++++++++
 tb/tb_instr_fetch.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Fetch-unit bus: synchronous ROM read port, decoder valid/ready handshake and jump redirect.
// Master is the fetch unit; slave is the ROM/decoder/control side.
interface instr_fetch_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
);
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic [DATA_W-1:0] instr_op;
    logic [DATA_W-1:0] instr_arg;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;
    logic              instr_err;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;

    modport master (
        output rom_addr,
        input  rom_data,
        output instr_op,
        output instr_arg,
        output instr_pc,
        output instr_valid,
        input  instr_ready,
        output instr_err,
        input  redirect_valid,
        input  redirect_pc
    );

    modport slave (
        input  rom_addr,
        output rom_data,
        input  instr_op,
        input  instr_arg,
        input  instr_pc,
        input  instr_valid,
        output instr_ready,
        input  instr_err,
        output redirect_valid,
        output redirect_pc
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch: assembles 1/2-word instructions from a sync ROM; valid 2/4 cycles after FETCH_OP, held until instr_ready.
// Redirect has priority over everything but reset; FETCH_LEN_CHECK_EN makes length bits 2'b11 an illegal one-word instruction.
module instr_fetch #(
    parameter int unsigned       ADDR_W   = 16,
    parameter int unsigned       DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    instr_fetch_if.master bus
);
    typedef enum logic [2:0] {
        S_FETCH_OP,
        S_WAIT_OP,
        S_FETCH_ARG,
        S_WAIT_ARG,
        S_HOLD
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_rom_addr;
    logic [ADDR_W-1:0] r_instr_pc;
    logic [DATA_W-1:0] r_instr_op;
    logic [DATA_W-1:0] r_instr_arg;
    logic              r_instr_valid;
    logic              r_two;

    logic [ADDR_W-1:0] w_pc_nxt;
    logic [ADDR_W-1:0] w_rom_addr_nxt;
    logic [ADDR_W-1:0] w_instr_pc_nxt;
    logic [DATA_W-1:0] w_instr_op_nxt;
    logic [DATA_W-1:0] w_instr_arg_nxt;
    logic              w_instr_valid_nxt;
    logic              w_two_nxt;

    logic              w_two_word;
    logic              w_hs;
    logic [ADDR_W-1:0] w_pc_plus1;
    logic [ADDR_W-1:0] w_pc_plus_len;

    assign w_hs          = (r_state == S_HOLD) && bus.instr_ready;
    assign w_pc_plus1    = r_pc + ADDR_W'(1);
    assign w_pc_plus_len = r_pc + (r_two ? ADDR_W'(2) : ADDR_W'(1));

`ifdef FETCH_LEN_CHECK_EN
    logic r_err;
    logic w_err_nxt;
    logic w_illegal;

    assign w_illegal  = (bus.rom_data[1:0] == 2'b11);
    assign w_two_word = bus.rom_data[1] && !w_illegal;
`else
    assign w_two_word = bus.rom_data[1];
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_FETCH_OP;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.redirect_valid) begin
            w_state_nxt = S_FETCH_OP;
        end else begin
            case (r_state)
                S_FETCH_OP:  w_state_nxt = S_WAIT_OP;
                S_WAIT_OP:   w_state_nxt = w_two_word ? S_FETCH_ARG : S_HOLD;
                S_FETCH_ARG: w_state_nxt = S_WAIT_ARG;
                S_WAIT_ARG:  w_state_nxt = S_HOLD;
                S_HOLD:      w_state_nxt = bus.instr_ready ? S_FETCH_OP : S_HOLD;
                default:     w_state_nxt = S_FETCH_OP;
            endcase
        end
    end

    // Next values of the registered outputs; a redirect discards whatever is in flight.
    always_comb begin
        w_pc_nxt          = r_pc;
        w_rom_addr_nxt    = r_rom_addr;
        w_instr_pc_nxt    = r_instr_pc;
        w_instr_op_nxt    = r_instr_op;
        w_instr_arg_nxt   = r_instr_arg;
        w_instr_valid_nxt = r_instr_valid;
        w_two_nxt         = r_two;
`ifdef FETCH_LEN_CHECK_EN
        w_err_nxt         = r_err;
`endif
        if (bus.redirect_valid) begin
            w_pc_nxt          = bus.redirect_pc;
            w_rom_addr_nxt    = bus.redirect_pc;
            w_instr_valid_nxt = 1'b0;
`ifdef FETCH_LEN_CHECK_EN
            w_err_nxt         = 1'b0;
`endif
        end else begin
            case (r_state)
                S_WAIT_OP: begin
                    w_instr_op_nxt = bus.rom_data;
                    w_instr_pc_nxt = r_pc;
                    w_two_nxt      = w_two_word;
`ifdef FETCH_LEN_CHECK_EN
                    w_err_nxt      = w_illegal;
`endif
                    if (w_two_word) begin
                        w_rom_addr_nxt = w_pc_plus1;
                    end else begin
                        w_instr_arg_nxt   = '0;
                        w_instr_valid_nxt = 1'b1;
                    end
                end
                S_WAIT_ARG: begin
                    w_instr_arg_nxt   = bus.rom_data;
                    w_instr_valid_nxt = 1'b1;
                end
                S_HOLD: begin
                    if (w_hs) begin
                        w_instr_valid_nxt = 1'b0;
                        w_pc_nxt          = w_pc_plus_len;
                        w_rom_addr_nxt    = w_pc_plus_len;
`ifdef FETCH_LEN_CHECK_EN
                        w_err_nxt         = 1'b0;
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc          <= RESET_PC;
            r_rom_addr    <= RESET_PC;
            r_instr_pc    <= RESET_PC;
            r_instr_op    <= '0;
            r_instr_arg   <= '0;
            r_instr_valid <= 1'b0;
            r_two         <= 1'b0;
        end else begin
            r_pc          <= w_pc_nxt;
            r_rom_addr    <= w_rom_addr_nxt;
            r_instr_pc    <= w_instr_pc_nxt;
            r_instr_op    <= w_instr_op_nxt;
            r_instr_arg   <= w_instr_arg_nxt;
            r_instr_valid <= w_instr_valid_nxt;
            r_two         <= w_two_nxt;
        end
    end

`ifdef FETCH_LEN_CHECK_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_err_nxt;
        end
    end

    assign bus.instr_err = r_err;
`else
    assign bus.instr_err = 1'b0;
`endif

    assign bus.rom_addr    = r_rom_addr;
    assign bus.instr_op    = r_instr_op;
    assign bus.instr_arg   = r_instr_arg;
    assign bus.instr_pc    = r_instr_pc;
    assign bus.instr_valid = r_instr_valid;
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed test-plan steps followed by random ready/redirect traffic against an instruction-level model.
module tb_instr_fetch;
`ifdef FETCH_LEN_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    int   hs_cnt = 0;
    logic [15:0] rom [65536];

    instr_fetch_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    instr_fetch #(.ADDR_W(16), .DATA_W(16), .RESET_PC(16'h0001)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: data for the sampled address appears after the edge.
    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    always @(posedge clk) if (rst && bus.instr_valid && bus.instr_ready) hs_cnt <= hs_cnt + 1;

    // Instruction-level model: what the decoder should see for an instruction starting at pc.
    function automatic logic [15:0] m_nxt(input logic [15:0] a);
        return a + 16'd1;
    endfunction
    function automatic bit m_two(input logic [15:0] pc);
        logic [15:0] op;
        op = rom[pc];
        return op[1] && !(CHK && op[0]);
    endfunction
    function automatic int m_len(input logic [15:0] pc);
        return m_two(pc) ? 2 : 1;
    endfunction
    function automatic logic [15:0] m_arg(input logic [15:0] pc);
        return m_two(pc) ? rom[m_nxt(pc)] : 16'h0000;
    endfunction
    function automatic bit m_err(input logic [15:0] pc);
        return CHK && (rom[pc][1:0] == 2'b11);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_instr(input string tag, input logic [15:0] pc);
        check({tag, "_valid"}, 32'(bus.instr_valid), 32'd1);
        check({tag, "_op"},    32'(bus.instr_op),    32'(rom[pc]));
        check({tag, "_arg"},   32'(bus.instr_arg),   32'(m_arg(pc)));
        check({tag, "_pc"},    32'(bus.instr_pc),    32'(pc));
        check({tag, "_err"},   32'(bus.instr_err),   32'(m_err(pc)));
    endtask

    // Steps negedges until instr_valid; the number of steps taken is the latency.
    task automatic wait_valid(input string tag, input int exp_cycles);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.instr_valid && n < 20);
        check({tag, "_lat"}, 32'(n), 32'(exp_cycles));
    endtask

    initial begin
        logic [15:0] exp_pc;
        logic [15:0] tgt;
        int          since;
        bit          first;
        bit          rdy;
        bit          redir;
        int          hs0;

        for (int i = 0; i < 65536; i++) rom[i] = 16'($urandom);
        rom[16'h0000] = 16'hBEEF;
        rom[16'h0001] = 16'h1702;
        rom[16'h0002] = 16'h0032;
        rom[16'h0003] = 16'h0001;
        rom[16'h0004] = 16'h0010;
        rom[16'h0005] = 16'h0102;
        rom[16'h0007] = 16'h0202;
        rom[16'h0032] = 16'h1236;
        rom[16'h0200] = 16'h0003;
        rom[16'h0201] = 16'h5555;
        rom[16'h0202] = 16'h0000;
        rom[16'hFFFF] = 16'h0002;

        bus.instr_ready    = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 16'h0000;
        rst                = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_addr",  32'(bus.rom_addr),    32'h0001);
        check("rst_op",    32'(bus.instr_op),    32'h0000);
        check("rst_arg",   32'(bus.instr_arg),   32'h0000);
        check("rst_pc",    32'(bus.instr_pc),    32'h0001);
        check("rst_valid", 32'(bus.instr_valid), 32'd0);
        check("rst_err",   32'(bus.instr_err),   32'd0);

        // Two-word instruction at RESET_PC, then the one-word at 3.
        rst = 1'b1;
        bus.instr_ready = 1'b1;
        wait_valid("i1", 4);
        check("i1_op",  32'(bus.instr_op),  32'h1702);
        check("i1_arg", 32'(bus.instr_arg), 32'h0032);
        check("i1_pc",  32'(bus.instr_pc),  32'h0001);
        @(negedge clk);
        check("i1_drop", 32'(bus.instr_valid), 32'd0);
        check("i1_next", 32'(bus.rom_addr),    32'h0003);
        bus.instr_ready = 1'b0;
        wait_valid("i3", 2);
        check("i3_op",  32'(bus.instr_op),  32'h0001);
        check("i3_arg", 32'(bus.instr_arg), 32'h0000);
        check("i3_pc",  32'(bus.instr_pc),  32'h0003);

        // Backpressure: everything holds still.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(bus.instr_valid), 32'd1);
            check("hold_op",    32'(bus.instr_op),    32'h0001);
            check("hold_addr",  32'(bus.rom_addr),    32'h0003);
        end
        bus.instr_ready = 1'b1;
        @(negedge clk);
        check("rel_valid", 32'(bus.instr_valid), 32'd0);
        check("rel_addr",  32'(bus.rom_addr),    32'h0004);

        wait_valid("i4", 2);
        expect_instr("i4", 16'h0004);
        wait_valid("i5", 5);
        expect_instr("i5", 16'h0005);

        // Redirect while the two-word at 7 waits for its operand.
        repeat (4) @(negedge clk);
        check("warg_valid", 32'(bus.instr_valid), 32'd0);
        check("warg_addr",  32'(bus.rom_addr),    32'h0008);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'h0032;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        check("rd1_valid", 32'(bus.instr_valid), 32'd0);
        check("rd1_addr",  32'(bus.rom_addr),    32'h0032);
        wait_valid("rd1", 4);
        expect_instr("rd1", 16'h0032);
        check("rd1_op", 32'(bus.instr_op), 32'h1236);

        // Redirect coinciding with a handshake; target exercises PC wrap.
        hs0 = hs_cnt;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'hFFFF;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        check("rdhs_valid", 32'(bus.instr_valid), 32'd0);
        check("rdhs_addr",  32'(bus.rom_addr),    32'hFFFF);
        check("rdhs_cnt",   32'(hs_cnt - hs0),    32'd1);
        wait_valid("wrap", 4);
        check("rdhs_cnt2",  32'(hs_cnt - hs0),    32'd1);
        check("wrap_op",  32'(bus.instr_op),  32'h0002);
        check("wrap_arg", 32'(bus.instr_arg), 32'hBEEF);
        check("wrap_pc",  32'(bus.instr_pc),  32'hFFFF);
        wait_valid("after_wrap", 5);
        check("after_wrap_pc", 32'(bus.instr_pc), 32'h0001);

        // Length bits 2'b11.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'h0200;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        wait_valid("ill", CHK ? 2 : 4);
        check("ill_err", 32'(bus.instr_err), 32'(CHK));
        check("ill_arg", 32'(bus.instr_arg), CHK ? 32'h0000 : 32'h5555);
        wait_valid("ill_next", 3);
        check("ill_next_pc",  32'(bus.instr_pc),  CHK ? 32'h0201 : 32'h0202);
        check("ill_next_err", 32'(bus.instr_err), 32'd0);

        // Random ready/redirect traffic against the model.
        exp_pc             = 16'($urandom);
        bus.instr_ready    = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = exp_pc;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        since = 1;
        first = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (bus.instr_valid) begin
                expect_instr("rnd", exp_pc);
                if (first) begin
                    check("rnd_lat", 32'(since), 32'(2 * m_len(exp_pc) + 1));
                    first = 1'b0;
                end
            end else if (since > 5) begin
                check("rnd_stall", 32'(since), 32'd5);
                since = 0;
            end
            rdy   = ($urandom_range(0, 2) != 0);
            redir = ($urandom_range(0, 24) == 0);
            tgt   = 16'($urandom);
            bus.instr_ready    = rdy;
            bus.redirect_valid = redir;
            bus.redirect_pc    = tgt;
            if (redir) begin
                exp_pc = tgt;
                since  = 0;
                first  = 1'b1;
            end else if (bus.instr_valid && rdy) begin
                exp_pc = exp_pc + 16'(m_len(exp_pc));
                since  = 0;
                first  = 1'b1;
            end
            @(negedge clk);
            since++;
        end

        // Reset beats a simultaneous redirect and handshake.
        bus.instr_ready    = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 16'h4444;
        rst                = 1'b0;
        @(negedge clk);
        check("mrst_addr",  32'(bus.rom_addr),    32'h0001);
        check("mrst_pc",    32'(bus.instr_pc),    32'h0001);
        check("mrst_valid", 32'(bus.instr_valid), 32'd0);
        check("mrst_op",    32'(bus.instr_op),    32'h0000);
        check("mrst_err",   32'(bus.instr_err),   32'd0);
        rst                = 1'b1;
        bus.redirect_valid = 1'b0;
        wait_valid("mrst", 4);
        check("mrst_op2", 32'(bus.instr_op), 32'h1702);
        check("mrst_pc2", 32'(bus.instr_pc), 32'h0001);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
